// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for the single-cycle core: periodic strobe in run mode, one strobe per debounced press in step mode.
// Optional debounce stage is compiled in with `define CPU_STEP_DEBOUNCE_EN; otherwise the synchronized button feeds the FSM directly.
module cpu_step_ctrl #(
    parameter int DIV       = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic        in,
    input  logic        rst,
    input  logic        sel,
    input  logic        step,
    output logic        ce,
    output logic        busy,
    output logic [15:0] tick_cnt
);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    if (DIV < 1 || DIV > 65535) begin : g_bad_div
        $error("cpu_step_ctrl: DIV out of range 1..65535");
    end
    if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_db
        $error("cpu_step_ctrl: DB_CYCLES out of range 1..65535");
    end

    logic        step_m;
    logic        step_s;
    logic        sel_q;
    logic        step_db;
    logic        step_db_d;
    logic        step_rise;
    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] cnt;

    always_ff @(posedge in) begin
        if (rst) begin
            step_m <= 1'b0;
            step_s <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            step_m <= step;
            step_s <= step_m;
            sel_q  <= sel;
        end
    end

`ifdef CPU_STEP_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [15:0] db_cnt;

    // step_db only moves after step_s has disagreed with it for DB_CYCLES straight cycles
    always_ff @(posedge in) begin
        if (rst) begin
            step_db <= 1'b0;
            db_cnt  <= 16'd0;
        end else if (step_s == step_db) begin
            db_cnt  <= 16'd0;
        end else if (db_cnt == DB_LAST) begin
            step_db <= step_s;
            db_cnt  <= 16'd0;
        end else begin
            db_cnt  <= db_cnt + 16'd1;
        end
    end
`else
    assign step_db = step_s;
`endif

    always_ff @(posedge in) begin
        if (rst) begin
            step_db_d <= 1'b0;
        end else begin
            step_db_d <= step_db;
        end
    end

    assign step_rise = step_db & ~step_db_d;

    // mode change is checked before step_rise so a coincident press is dropped
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (sel_q) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!sel_q)         state_nxt = RUN;
                else if (step_rise) state_nxt = S_PULSE;
            end
            S_PULSE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!sel_q)       state_nxt = RUN;
                else if (!step_db) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge in) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= 16'd0;
            ce       <= 1'b0;
            busy     <= 1'b0;
            tick_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            // divider rests at zero outside RUN so every entry starts a fresh period
            if (state != RUN || state_nxt != RUN || cnt == DIV_LAST) begin
                cnt <= 16'd0;
            end else begin
                cnt <= cnt + 16'd1;
            end
            ce       <= (state == S_PULSE) || (state == RUN && cnt == DIV_LAST);
            busy     <= (state_nxt == S_PULSE) || (state_nxt == S_WAIT);
            tick_cnt <= tick_cnt + {15'd0, ce};
        end
    end

endmodule
